// File: rtl/noise_lane_sched.sv
// Round-robin scheduler sharing one noise generator among NUM_CH lanes; adds the
// granted lane's sym*gain to one noise sample and saturates to signed 8 bits.
module noise_lane_sched #(
  parameter int NUM_CH  = 4,
  parameter int GAIN_W  = 6,
  parameter int TIMEOUT = 16,
  localparam int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*8-1:0]      ch_sym,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic                     noise_en,
  input  logic [7:0]               noise_in,
  input  logic                     noise_in_valid,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic [PW-1:0]            out_ch,
  output logic                     out_timeout,
  output logic                     abort,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);

  localparam int PRW = 9 + GAIN_W;
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic signed [PRW-1:0] SAT_HI = PRW'(127);
  localparam logic signed [PRW-1:0] SAT_LO = PRW'(-128);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     lane;
  logic [7:0]        sym_q;
  logic [GAIN_W-1:0] gain_q;
  logic [CW-1:0]     wait_cnt;
  logic [NUM_CH-1:0] grant_q;
  logic              abort_q;
  logic [7:0]        out_data_q;
  logic [PW-1:0]     out_ch_q;
  logic              timeout_q;
  logic [15:0]       drop_cnt_q;

  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  int                j;

  // First requester at or above rr_ptr, wrapping; works for non-power-of-2 NUM_CH.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!pick_found && ch_req[j]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(j);
      end
    end
  end

  logic signed [PRW-1:0] prod;
  logic signed [PRW-1:0] noise_ext;
  logic signed [PRW-1:0] sum_n;

  always_comb begin
    prod      = $signed({{(PRW-8){sym_q[7]}}, sym_q}) *
                $signed({{(PRW-GAIN_W){1'b0}}, gain_q});
    noise_ext = $signed({{(PRW-8){noise_in[7]}}, noise_in});
    sum_n     = prod + noise_ext;
  end

  function automatic logic [7:0] sat8(input logic signed [PRW-1:0] v);
    if (v > SAT_HI)      return 8'h7f;
    else if (v < SAT_LO) return 8'h80;
    else                 return v[7:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      lane       <= '0;
      sym_q      <= '0;
      gain_q     <= '0;
      wait_cnt   <= '0;
      grant_q    <= '0;
      abort_q    <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      timeout_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      grant_q <= '0;
      abort_q <= 1'b0;
      if (noise_in_valid && state != S_WAIT && drop_cnt_q != 16'hffff)
        drop_cnt_q <= drop_cnt_q + 16'd1;
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (en && pick_found) begin
            lane    <= pick_idx;
            sym_q   <= ch_sym[8*pick_idx +: 8];
            gain_q  <= ch_gain[GAIN_W*pick_idx +: GAIN_W];
            grant_q <= NUM_CH'(1) << pick_idx;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!en) begin
            abort_q <= 1'b1;
            state   <= S_IDLE;
          end else if (noise_in_valid) begin
            out_data_q <= sat8(sum_n);
            out_ch_q   <= lane;
            timeout_q  <= 1'b0;
            state      <= S_OUT;
          end else if (wait_cnt == CW'(TIMEOUT-1)) begin
            out_data_q <= sat8(prod);
            out_ch_q   <= lane;
            timeout_q  <= 1'b1;
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          wait_cnt <= '0;
          rr_ptr   <= (lane == PW'(NUM_CH-1)) ? '0 : lane + 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ch_grant    = grant_q;
  assign noise_en    = (state == S_WAIT);
  assign busy        = (state != S_IDLE);
  assign out_valid   = (state == S_OUT);
  assign out_timeout = (state == S_OUT) && timeout_q;
  assign out_data    = out_data_q;
  assign out_ch      = out_ch_q;
  assign abort       = abort_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_noise_lane_sched.sv
// Scoreboard bench for noise_lane_sched: directed transactions push expected results,
// a negedge monitor pops and compares on every out_valid.
module tb_noise_lane_sched;

  localparam int NUM_CH  = 4;
  localparam int GAIN_W  = 6;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  ch_req = '0;
  logic [31:0] ch_sym = '0;
  logic [23:0] ch_gain = '0;
  logic [3:0]  ch_grant;
  logic        noise_en;
  logic [7:0]  noise_in = '0;
  logic        noise_in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic        out_timeout;
  logic        abort;
  logic        busy;
  logic [15:0] drop_cnt;

  noise_lane_sched #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_req(ch_req), .ch_sym(ch_sym),
    .ch_gain(ch_gain), .ch_grant(ch_grant), .noise_en(noise_en),
    .noise_in(noise_in), .noise_in_valid(noise_in_valid), .out_data(out_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_timeout(out_timeout),
    .abort(abort), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       to;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [7:0] s, input logic [5:0] g);
    ch_sym[8*l +: 8]  = s;
    ch_gain[6*l +: 6] = g;
  endtask

  task automatic push_exp(input logic [7:0] d, input int l, input logic to);
    exp_t e;
    e.d  = d;
    e.ch = l[1:0];
    e.to = to;
    sbq.push_back(e);
  endtask

  task automatic wait_grant(input logic [3:0] exp_g);
    int n;
    n = 0;
    while (ch_grant == 4'b0 && n < 20) begin
      tick;
      n++;
    end
    check("grant", {28'b0, ch_grant}, {28'b0, exp_g});
  endtask

  // One granted transaction with noise valid in WAIT cycle 1.
  task automatic run_one(input int l, input logic [7:0] s, input logic [5:0] g,
                         input logic [7:0] n, input logic [7:0] exp_d);
    set_lane(l, s, g);
    noise_in       = n;
    noise_in_valid = 1'b0;
    push_exp(exp_d, l, 1'b0);
    ch_req = 4'b0001 << l;
    wait_grant(4'b0001 << l);
    check("wait_flags", {30'b0, noise_en, busy}, 32'd3);
    ch_req         = 4'b0;
    noise_in_valid = 1'b1;
    tick;
    check("out_latency", {31'b0, out_valid}, 32'd1);
    noise_in_valid = 1'b0;
    tick;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      check("out_exclusive", {30'b0, ch_grant != 4'b0, abort}, 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_out", {31'b0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_data", {24'b0, out_data}, {24'b0, e.d});
        check("out_ch", {30'b0, out_ch}, {30'b0, e.ch});
        check("out_timeout", {31'b0, out_timeout}, {31'b0, e.to});
      end
    end
  end

  initial begin
    #2;
    check("reset_outs", {13'b0, ch_grant, noise_en, busy, out_valid, out_timeout,
                         abort, out_ch, out_data}, 32'd0);
    check("reset_drop", {16'b0, drop_cnt}, 32'd0);
    #20 rst = 1'b0;
    en = 1'b1;
    tick;

    // single lane and saturation corners
    run_one(0, 8'sd1, 6'd28, -8'sd1, 8'd27);
    run_one(1, 8'sd5, 6'd28, 8'sd0, 8'h7f);
    run_one(2, -8'sd5, 6'd28, -8'sd1, 8'h80);
    run_one(3, -8'sd1, 6'd0, 8'sd1, 8'd1);

    // round robin with all lanes requesting and noise always valid
    for (int i = 0; i < 4; i++) set_lane(i, 8'(i + 1), 6'd2);
    noise_in       = 8'd0;
    noise_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(8'(2 * ((k % 4) + 1)), k % 4, 1'b0);
    ch_req = 4'hf;
    wait_grant(4'b0001);
    for (int k = 1; k < 5; k++) begin
      tick; tick; tick;
      check("rr_grant", {28'b0, ch_grant}, {28'b0, 4'b0001 << (k % 4)});
    end
    ch_req = 4'b0;
    tick;
    noise_in_valid = 1'b0;
    tick;

    // timeout on lane 2 with negative saturation of sym*gain
    set_lane(2, -8'sd100, 6'd3);
    push_exp(8'h80, 2, 1'b1);
    ch_req = 4'b0100;
    wait_grant(4'b0100);
    ch_req = 4'b0;
    repeat (TIMEOUT - 1) tick;
    check("to_last_wait", {30'b0, busy, out_valid}, 32'd2);
    tick;
    check("to_out", {30'b0, out_valid, out_timeout}, 32'd3);
    tick;

    // extreme negative product plus negative noise; leaves rr_ptr at 1
    run_one(0, 8'h80, 6'd63, 8'h80, 8'h80);

    // abort in WAIT cycle 3, then same lane wins again
    set_lane(1, 8'sd7, 6'd1);
    noise_in = 8'd0;
    ch_req   = 4'b0010;
    wait_grant(4'b0010);
    tick; tick;
    en = 1'b0;
    tick;
    check("abort", {29'b0, abort, noise_en, out_valid}, 32'd4);
    en     = 1'b1;
    ch_req = 4'b0011;
    push_exp(8'd7, 1, 1'b0);
    wait_grant(4'b0010);
    ch_req         = 4'b0;
    noise_in_valid = 1'b1;
    tick;
    noise_in_valid = 1'b0;
    tick;

    // drop counter from a clean reset
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick;
    repeat (3) begin
      noise_in_valid = 1'b1;
      tick;
      noise_in_valid = 1'b0;
      tick;
    end
    check("drop_cnt", {16'b0, drop_cnt}, 32'd3);
    run_one(2, 8'sd10, 6'd5, 8'sd3, 8'd53);
    check("drop_hold", {16'b0, drop_cnt}, 32'd3);

    // asynchronous reset in the middle of WAIT
    set_lane(3, 8'sd20, 6'd1);
    ch_req = 4'b1000;
    wait_grant(4'b1000);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {13'b0, ch_grant, noise_en, busy, out_valid, out_timeout,
                        abort, out_ch, out_data}, 32'd0);
    check("rst_drop", {16'b0, drop_cnt}, 32'd0);
    #2 rst = 1'b0;
    ch_req = 4'hf;
    set_lane(0, 8'sd9, 6'd1);
    noise_in = 8'd0;
    push_exp(8'd9, 0, 1'b0);
    wait_grant(4'b0001);
    ch_req         = 4'b0;
    noise_in_valid = 1'b1;
    tick;
    noise_in_valid = 1'b0;
    tick; tick; tick;

    check("sb_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/noise_lane_sched.md
# noise_lane_sched

Round-robin scheduler that shares one noise-generator stream among NUM_CH receiver-sim lanes. It arbitrates lane requests and gates the generator enable. It then combines the granted lane's symbol, scaled by a per-lane gain, with one noise sample, and saturates the result to signed 8 bits. It sits between the symbol sources and the shared noise generator in the Rx simulation path, with a timeout so a stalled generator cannot hang a lane.

## Interface
- NUM_CH, 4, number of requesting lanes (2..8)
- GAIN_W, 6, width of unsigned per-lane gain
- TIMEOUT, 16, max WAIT cycles before noiseless completion (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global enable; low blocks new grants and aborts WAIT
- ch_req  in  NUM_CH  per-lane request, level, held until granted
- ch_sym  in  NUM_CH*8  packed signed symbols, lane i at [8i+7:8i]
- ch_gain  in  NUM_CH*GAIN_W  packed unsigned gains
- ch_grant  out  NUM_CH  one-hot, one-cycle grant pulse
- noise_en  out  1  enable to shared noise generator
- noise_in  in  8  signed noise sample
- noise_in_valid  in  1  noise sample valid
- out_data  out  8  signed saturated sum
- out_valid  out  1  one-cycle result strobe
- out_ch  out  clog2(NUM_CH)  lane index of out_data
- out_timeout  out  1  high with out_valid when noise was substituted by 0
- abort  out  1  one-cycle pulse, WAIT abandoned due to en low
- busy  out  1  high in WAIT and OUT
- drop_cnt  out  16  noise samples received outside WAIT, saturating

## Operation
- States: IDLE, WAIT, OUT. Reset → IDLE.
- IDLE: noise_en=0. If en=1 and ch_req≠0, choose the first requesting lane searching upward from rr_ptr with wrap. Latch lane index, symbol and gain. Go to WAIT.
- WAIT: noise_en=1, busy=1, and wait_cnt increments each cycle.
  - If en=0: go to IDLE, pulse abort. No output. rr_ptr is unchanged, so the same lane wins again if still requesting.
  - Else if noise_in_valid=1: sum = sym*gain + noise_in. Go to OUT.
  - Else if wait_cnt = TIMEOUT-1: sum = sym*gain, set out_timeout. Go to OUT.
  - Priority within WAIT: en low > noise valid > timeout.
- OUT: out_valid=1 for one cycle. out_data and out_ch are held until the next OUT. rr_ptr = (lane+1) mod NUM_CH. Go to IDLE.
- Arithmetic:
  - sym is signed 8; gain is unsigned, zero-extended.
  - The product is computed in signed 9+GAIN_W bits; noise_in is sign-extended to that width.
  - Saturate the sum to [-128, 127].
- drop_cnt increments on every noise_in_valid cycle while the state is not WAIT. It sticks at 0xFFFF.
- Reset, including mid-WAIT, returns asynchronously to IDLE. rr_ptr=0 and wait_cnt=0; every output goes to 0, including drop_cnt and out_data.
- ch_req changes in WAIT/OUT are ignored until the next IDLE. A lane dropping its request after grant still completes.

## Timing
- Request sampled at edge E0 (state IDLE).
- The state is WAIT in cycle 1. ch_grant is high for exactly cycle 1, and noise_en goes high in cycle 1.
- If noise_in_valid=1 in cycle k of WAIT, then OUT is cycle k+1 with out_valid, and IDLE follows in cycle k+2.
- Minimum: out_valid in cycle 2 after the sampling edge; back-to-back grants every 3 cycles.
- Timeout: WAIT lasts TIMEOUT cycles (cycles 1..TIMEOUT). out_valid and out_timeout are in cycle TIMEOUT+1.
- abort is asserted in the cycle after en is sampled low in WAIT, when the state is IDLE. noise_en is 0 in that same cycle.
- Grant, out_valid and abort are never high simultaneously.

## Test plan
- Single lane (NUM_CH=4, GAIN_W=6, TIMEOUT=16): ch_req=0001, sym0=+1, gain0=28, noise_in=-1 valid in cycle 1 → ch_grant=0001 in cycle 1, out_valid in cycle 2 with out_data=27, out_ch=0, out_timeout=0.
- Saturation:
  - sym=+5, gain=28, noise=0 → out_data=127.
  - sym=-5, gain=28, noise=-1 → out_data=-128.
  - sym=-1, gain=0, noise=+1 → out_data=1.
- Round robin: ch_req=1111 held, noise_in_valid=1 constant → grants 0001, 0010, 0100, 1000, 0001 every 3 cycles, with out_ch 0, 1, 2, 3, 0.
- Timeout: ch_req=0100, noise_in_valid=0 → grant in cycle 1, out_valid=1 with out_timeout=1 in cycle 17, out_data=sat(sym2*gain2).
- Abort: grant lane 1, drop en in WAIT cycle 3 → abort pulse, no out_valid. Re-raise en with ch_req=0011 → next grant is 0010.
- Drops/reset: 3 noise_in_valid pulses in IDLE → drop_cnt=3. Then assert rst mid-WAIT → all outputs 0 immediately, without waiting for a clock edge; after release, the first grant goes to lane 0.
